// File: rtl/mem_stage_if.sv
// Bus bundle between the execute stage, the memory stage, the data memory
// and the writeback side.
//   in_*       : instruction presented by the execute stage
//   stall      : execute must hold in_* while high
//   dmem_*     : data-memory request (registered strobes) and response
//   out_*      : registered writeback-side result
// slave  : view used by mem_stage
// master : view used by whatever drives the execute side and models memory
interface mem_stage_if;
  logic        in_valid;
  logic        in_load;
  logic        in_store;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [31:0] in_alu;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic        in_load_regfile;

  logic        stall;

  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  logic        out_valid;
  logic [4:0]  out_rd;
  logic        out_we;
  logic [31:0] out_data;
  logic        out_misaligned;

  modport slave (
    input  in_valid, in_load, in_store, in_size, in_unsigned, in_alu,
           in_wdata, in_rd, in_load_regfile, dmem_rdata, dmem_resp,
    output stall, dmem_read, dmem_write, dmem_addr, dmem_wmask, dmem_wdata,
           out_valid, out_rd, out_we, out_data, out_misaligned
  );

  modport master (
    output in_valid, in_load, in_store, in_size, in_unsigned, in_alu,
           in_wdata, in_rd, in_load_regfile, dmem_rdata, dmem_resp,
    input  stall, dmem_read, dmem_write, dmem_addr, dmem_wmask, dmem_wdata,
           out_valid, out_rd, out_we, out_data, out_misaligned
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage of a simple in-order pipeline. Non-memory ops and misaligned
// accesses pass through in one cycle; aligned loads/stores latch their
// operands, raise a registered request and wait (unbounded) for dmem_resp.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : mem_stage_if.slave (execute inputs, stall, dmem request and
//           response, registered writeback result)
module mem_stage (
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [4:0]  rd_q, rd_d;
  logic        we_q, we_d;
  logic        load_q, load_d;
  logic        dmem_read_q, dmem_read_d;
  logic        dmem_write_q, dmem_write_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] wdata_q, wdata_d;
  logic        out_valid_q, out_valid_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        out_we_q, out_we_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_mis_q, out_mis_d;
  logic [1:0]  size_in;

  // Size code 3 behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    logic [1:0] r;
    r = (s == 2'd3) ? 2'd2 : s;
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] s, input logic [1:0] off);
    logic r;
    case (s)
      2'd1:    r = off[0];
      2'd2:    r = (off != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] s, input logic [1:0] off);
    logic [3:0] r;
    case (s)
      2'd0:    r = 4'b0001 << off;
      2'd1:    r = 4'b0011 << off;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Replicating the datum places it in every lane the mask can select.
  function automatic logic [31:0] lane_data(input logic [1:0] s, input logic [31:0] w);
    logic [31:0] r;
    case (s)
      2'd0:    r = {4{w[7:0]}};
      2'd1:    r = {2{w[15:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] s, input logic uns,
                                              input logic [1:0] off, input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] r;
    sh = rdata >> {off, 3'b000};
    case (s)
      2'd0:    r = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    r = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  assign size_in = norm_size(bus.in_size);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    rd_d         = rd_q;
    we_d         = we_q;
    load_d       = load_q;
    dmem_read_d  = dmem_read_q;
    dmem_write_d = dmem_write_q;
    wmask_d      = wmask_q;
    wdata_d      = wdata_q;
    out_valid_d  = 1'b0;
    out_we_d     = 1'b0;
    out_mis_d    = 1'b0;
    out_data_d   = out_data_q;
    out_rd_d     = out_rd_q;

    case (state_q)
      IDLE: begin
        // A stray dmem_resp here is ignored; only in_valid matters.
        if (bus.in_valid) begin
          if (!(bus.in_load || bus.in_store)) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_alu;
            out_we_d    = bus.in_load_regfile;
            out_rd_d    = bus.in_rd;
          end else if (is_misaligned(size_in, bus.in_alu[1:0])) begin
            out_valid_d = 1'b1;
            out_mis_d   = 1'b1;
            out_data_d  = bus.in_alu;
            out_rd_d    = bus.in_rd;
          end else begin
            // Load wins when both load and store are flagged.
            state_d      = ACCESS;
            addr_d       = bus.in_alu;
            size_d       = size_in;
            uns_d        = bus.in_unsigned;
            rd_d         = bus.in_rd;
            we_d         = bus.in_load_regfile;
            load_d       = bus.in_load;
            dmem_read_d  = bus.in_load;
            dmem_write_d = !bus.in_load;
            wmask_d      = bus.in_load ? 4'b0000 : lane_mask(size_in, bus.in_alu[1:0]);
            wdata_d      = lane_data(size_in, bus.in_wdata);
          end
        end
      end
      ACCESS: begin
        // in_* are ignored for the whole access, including the resp cycle.
        if (bus.dmem_resp) begin
          state_d      = IDLE;
          dmem_read_d  = 1'b0;
          dmem_write_d = 1'b0;
          wmask_d      = 4'b0000;
          out_valid_d  = 1'b1;
          out_rd_d     = rd_q;
          if (load_q) begin
            out_data_d = load_extend(size_q, uns_q, addr_q[1:0], bus.dmem_rdata);
            out_we_d   = we_q;
          end else begin
            out_data_d = addr_q;
          end
        end
      end
    endcase
  end

  // Control and architecturally visible outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      dmem_read_q  <= 1'b0;
      dmem_write_q <= 1'b0;
      wmask_q      <= 4'b0000;
      out_valid_q  <= 1'b0;
      out_we_q     <= 1'b0;
      out_mis_q    <= 1'b0;
      out_data_q   <= 32'd0;
      out_rd_q     <= 5'd0;
    end else begin
      state_q      <= state_d;
      dmem_read_q  <= dmem_read_d;
      dmem_write_q <= dmem_write_d;
      wmask_q      <= wmask_d;
      out_valid_q  <= out_valid_d;
      out_we_q     <= out_we_d;
      out_mis_q    <= out_mis_d;
      out_data_q   <= out_data_d;
      out_rd_q     <= out_rd_d;
    end
  end

  // Latched operands of the in-flight access
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    rd_q    <= rd_d;
    we_q    <= we_d;
    load_q  <= load_d;
    wdata_q <= wdata_d;
  end

  assign bus.stall          = (state_q == ACCESS);
  assign bus.dmem_read      = dmem_read_q;
  assign bus.dmem_write     = dmem_write_q;
  assign bus.dmem_addr      = {addr_q[31:2], 2'b00};
  assign bus.dmem_wmask     = wmask_q;
  assign bus.dmem_wdata     = wdata_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_rd         = out_rd_q;
  assign bus.out_we         = out_we_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_misaligned = out_mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written
// reset / idle-response sequences, and randomized ops against a byte-level
// reference model.
module tb_mem_stage;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_stage_if bus();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] rdata;
    int          waitc;
    logic [1:0]  e_strb;   // bit0 read, bit1 write
    logic [31:0] e_addr;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
    logic        e_we;
    logic        e_mis;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [1:0] sz,
                              input logic uns, input logic [31:0] alu, input logic [31:0] wdata,
                              input logic [4:0] rd, input logic we, input logic [31:0] rdata,
                              input int waitc, input logic [1:0] e_strb, input logic [31:0] e_addr,
                              input logic [3:0] e_mask, input logic [31:0] e_wdata,
                              input logic [31:0] e_data, input logic e_we, input logic e_mis);
    vec_t v;
    v.ld = ld; v.st = st; v.sz = sz; v.uns = uns; v.alu = alu; v.wdata = wdata;
    v.rd = rd; v.we = we; v.rdata = rdata; v.waitc = waitc; v.e_strb = e_strb;
    v.e_addr = e_addr; v.e_mask = e_mask; v.e_wdata = e_wdata; v.e_data = e_data;
    v.e_we = e_we; v.e_mis = e_mis;
    return v;
  endfunction

  function automatic logic [31:0] byte_lanes(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? 8'hFF : 8'h00;
    return r;
  endfunction

  // Reference model: works byte by byte from the access width and offset.
  function automatic vec_t model(input vec_t vin);
    vec_t v;
    int nb;
    int off;
    logic [31:0] val;
    v = vin;
    nb  = (v.sz == 2'd0) ? 1 : (v.sz == 2'd1) ? 2 : 4;
    off = int'(v.alu[1:0]);
    v.e_addr = v.alu & 32'hFFFF_FFFC;
    v.e_mask = 4'b0000; v.e_wdata = 32'd0; v.e_mis = 1'b0; v.e_strb = 2'd0;
    if (!v.ld && !v.st) begin
      v.e_data = v.alu; v.e_we = v.we;
    end else if ((off % nb) != 0) begin
      v.e_data = v.alu; v.e_we = 1'b0; v.e_mis = 1'b1;
    end else if (v.ld) begin
      v.e_strb = 2'd1;
      val = 32'd0;
      for (int i = 0; i < nb; i++) val[8*i +: 8] = v.rdata[8*(off+i) +: 8];
      if (!v.uns && nb < 4 && val[8*nb-1])
        for (int i = nb; i < 4; i++) val[8*i +: 8] = 8'hFF;
      v.e_data = val; v.e_we = v.we;
    end else begin
      v.e_strb = 2'd2;
      for (int i = 0; i < nb; i++) begin
        v.e_mask[off+i] = 1'b1;
        v.e_wdata[8*(off+i) +: 8] = v.wdata[8*i +: 8];
      end
      v.e_data = v.alu; v.e_we = 1'b0;
    end
    return v;
  endfunction

  task automatic run_op(input string nm, input vec_t v);
    int          stall_cnt;
    logic        bad;
    logic [69:0] snap;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_load = v.ld; bus.in_store = v.st; bus.in_size = v.sz;
    bus.in_unsigned = v.uns; bus.in_alu = v.alu; bus.in_wdata = v.wdata;
    bus.in_rd = v.rd; bus.in_load_regfile = v.we; bus.dmem_resp = 1'b0;
    bus.dmem_rdata = $urandom;
    @(posedge clk); #1;
    check({nm, " strobes"}, {30'd0, bus.dmem_write, bus.dmem_read}, {30'd0, v.e_strb});
    if (v.e_strb == 2'd0) begin
      check({nm, " stall"}, {31'd0, bus.stall}, 32'd0);
      check({nm, " out_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({nm, " out_data"}, bus.out_data, v.e_data);
      check({nm, " out_we"}, {31'd0, bus.out_we}, {31'd0, v.e_we});
      check({nm, " out_mis"}, {31'd0, bus.out_misaligned}, {31'd0, v.e_mis});
      if (!v.e_mis) check({nm, " out_rd"}, {27'd0, bus.out_rd}, {27'd0, v.rd});
    end else begin
      check({nm, " stall"}, {31'd0, bus.stall}, 32'd1);
      check({nm, " addr"}, bus.dmem_addr, v.e_addr);
      if (v.e_strb == 2'd2) begin
        check({nm, " wmask"}, {28'd0, bus.dmem_wmask}, {28'd0, v.e_mask});
        check({nm, " wdata"}, bus.dmem_wdata & byte_lanes(v.e_mask),
              v.e_wdata & byte_lanes(v.e_mask));
      end
      snap = {bus.dmem_read, bus.dmem_write, bus.dmem_addr, bus.dmem_wmask, bus.dmem_wdata};
      stall_cnt = 0;
      bad = 1'b0;
      for (int c = 0; c <= v.waitc; c++) begin
        @(negedge clk);
        if (bus.stall) stall_cnt++;
        if (bus.out_valid ||
            ({bus.dmem_read, bus.dmem_write, bus.dmem_addr, bus.dmem_wmask, bus.dmem_wdata} !== snap))
          bad = 1'b1;
        // Scrambled inputs during the access must have no effect.
        bus.in_alu = $urandom; bus.in_wdata = $urandom; bus.in_rd = 5'($urandom);
        bus.in_load = 1'($urandom); bus.in_store = 1'($urandom); bus.in_size = 2'($urandom);
        bus.in_load_regfile = 1'($urandom);
        bus.dmem_resp  = (c == v.waitc);
        bus.dmem_rdata = (c == v.waitc) ? v.rdata : $urandom;
      end
      @(posedge clk); #1;
      check({nm, " stall_cycles"}, stall_cnt, v.waitc + 1);
      check({nm, " hold_during_access"}, {31'd0, bad}, 32'd0);
      check({nm, " done out_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({nm, " done out_data"}, bus.out_data, v.e_data);
      check({nm, " done out_we"}, {31'd0, bus.out_we}, {31'd0, v.e_we});
      check({nm, " done out_rd"}, {27'd0, bus.out_rd}, {27'd0, v.rd});
      check({nm, " done out_mis"}, {31'd0, bus.out_misaligned}, 32'd0);
      check({nm, " done strobes"}, {30'd0, bus.dmem_write, bus.dmem_read}, 32'd0);
      check({nm, " done stall"}, {31'd0, bus.stall}, 32'd0);
    end
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, " stall"}, {31'd0, bus.stall}, 32'd0);
    check({nm, " strobes"}, {30'd0, bus.dmem_write, bus.dmem_read}, 32'd0);
    check({nm, " wmask"}, {28'd0, bus.dmem_wmask}, 32'd0);
    check({nm, " out_flags"}, {29'd0, bus.out_valid, bus.out_we, bus.out_misaligned}, 32'd0);
    check({nm, " out_data"}, bus.out_data, 32'd0);
    check({nm, " out_rd"}, {27'd0, bus.out_rd}, 32'd0);
  endtask

  vec_t tbl[15];
  vec_t rv;

  initial begin
    tbl[0]  = mk(0,0,2,0,32'h0000_1234,32'h0,5,1,32'h0,0,           0,32'h0,4'h0,32'h0,32'h0000_1234,1,0);
    tbl[1]  = mk(1,0,0,0,32'h0000_1003,32'h0,3,1,32'h80FF_FFFF,3,   1,32'h0000_1000,4'h0,32'h0,32'hFFFF_FF80,1,0);
    tbl[2]  = mk(1,0,1,1,32'h0000_2002,32'h0,4,1,32'hBEEF_0000,0,   1,32'h0000_2000,4'h0,32'h0,32'h0000_BEEF,1,0);
    tbl[3]  = mk(0,1,0,0,32'h0000_3001,32'h0000_00AA,6,1,32'h0,1,   2,32'h0000_3000,4'b0010,32'h0000_AA00,32'h0000_3001,0,0);
    tbl[4]  = mk(1,0,2,0,32'h0000_4002,32'h0,7,1,32'h0,0,           0,32'h0,4'h0,32'h0,32'h0000_4002,0,1);
    tbl[5]  = mk(0,1,1,0,32'h0000_4006,32'h1234_CAFE,8,1,32'h0,2,   2,32'h0000_4004,4'b1100,32'hCAFE_0000,32'h0000_4006,0,0);
    tbl[6]  = mk(1,0,1,0,32'h0000_0010,32'h0,9,1,32'h0000_8001,0,   1,32'h0000_0010,4'h0,32'h0,32'hFFFF_8001,1,0);
    tbl[7]  = mk(1,0,2,0,32'h0000_0020,32'h0,10,0,32'hDEAD_BEEF,1,  1,32'h0000_0020,4'h0,32'h0,32'hDEAD_BEEF,0,0);
    tbl[8]  = mk(1,0,3,1,32'h0000_0024,32'h0,11,1,32'h1234_5678,0,  1,32'h0000_0024,4'h0,32'h0,32'h1234_5678,1,0);
    tbl[9]  = mk(1,0,0,1,32'h0000_0031,32'h0,12,1,32'h0000_F000,0,  1,32'h0000_0030,4'h0,32'h0,32'h0000_00F0,1,0);
    tbl[10] = mk(1,1,2,0,32'h0000_0040,32'h0,13,1,32'hA5A5_A5A5,0,  1,32'h0000_0040,4'h0,32'h0,32'hA5A5_A5A5,1,0);
    tbl[11] = mk(0,1,1,0,32'h0000_0041,32'h0,14,1,32'h0,0,          0,32'h0,4'h0,32'h0,32'h0000_0041,0,1);
    tbl[12] = mk(0,0,0,0,32'hFFFF_FFFF,32'h0,7,0,32'h0,0,           0,32'h0,4'h0,32'h0,32'hFFFF_FFFF,0,0);
    tbl[13] = mk(0,1,2,0,32'h0000_0050,32'h0102_0304,15,1,32'h0,2,  2,32'h0000_0050,4'b1111,32'h0102_0304,32'h0000_0050,0,0);
    tbl[14] = mk(0,1,0,0,32'h0000_0053,32'h0000_007F,16,0,32'h0,0,  2,32'h0000_0050,4'b1000,32'h7F00_0000,32'h0000_0053,0,0);

    bus.in_valid = 1'b0; bus.in_load = 1'b0; bus.in_store = 1'b0; bus.in_size = 2'd0;
    bus.in_unsigned = 1'b0; bus.in_alu = 32'd0; bus.in_wdata = 32'd0; bus.in_rd = 5'd0;
    bus.in_load_regfile = 1'b0; bus.dmem_rdata = 32'd0; bus.dmem_resp = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) run_op($sformatf("vec%0d", i), tbl[i]);

    // Idle cycle after a non-mem op, with a stray response that must be ignored.
    run_op("add_before_idle", tbl[0]);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("idle out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("idle out_we", {31'd0, bus.out_we}, 32'd0);
    check("idle stray resp stall", {31'd0, bus.stall}, 32'd0);
    check("idle stray resp strobes", {30'd0, bus.dmem_write, bus.dmem_read}, 32'd0);

    // Reset in the middle of an access abandons it.
    @(negedge clk);
    bus.dmem_resp = 1'b0; bus.in_valid = 1'b1; bus.in_load = 1'b1; bus.in_store = 1'b0;
    bus.in_size = 2'd2; bus.in_alu = 32'h0000_5000; bus.in_rd = 5'd20; bus.in_load_regfile = 1'b1;
    @(posedge clk); #1;
    check("lw5000 read", {31'd0, bus.dmem_read}, 32'd1);
    check("lw5000 addr", bus.dmem_addr, 32'h0000_5000);
    @(negedge clk);
    bus.in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    check_reset_state("reset_in_access");
    @(negedge clk);
    reset = 1'b0; bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    check("late resp out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("late resp strobes", {30'd0, bus.dmem_write, bus.dmem_read}, 32'd0);
    check("late resp stall", {31'd0, bus.stall}, 32'd0);
    run_op("add_after_reset", tbl[0]);

    // Randomized ops, some back-to-back, some separated by idle cycles.
    for (int n = 0; n < 200; n++) begin
      int kind;
      int nb;
      kind = $urandom_range(0, 3);
      rv.ld = (kind == 1) || (kind == 3);
      rv.st = (kind == 2) || (kind == 3);
      rv.sz = 2'($urandom);
      rv.uns = 1'($urandom);
      rv.wdata = $urandom;
      rv.rd = 5'($urandom);
      rv.we = 1'($urandom);
      rv.rdata = $urandom;
      rv.waitc = $urandom_range(0, 3);
      nb = (rv.sz == 2'd0) ? 1 : (rv.sz == 2'd1) ? 2 : 4;
      rv.alu = $urandom;
      if ($urandom_range(0, 3) != 0) rv.alu = rv.alu & ~(32'(nb) - 32'd1);
      rv = model(rv);
      run_op($sformatf("rnd%0d", n), rv);
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        bus.in_valid = 1'b0; bus.dmem_resp = 1'($urandom);
        @(posedge clk); #1;
        check($sformatf("rnd%0d idle out_valid", n), {31'd0, bus.out_valid}, 32'd0);
        check($sformatf("rnd%0d idle stall", n), {31'd0, bus.stall}, 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
